// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: fp_Z = fp_X / fp_Y.
// Restoring radix-2 mantissa division, one quotient bit per clock, followed
// by one rounding cycle. Subnormal operands are flushed to zero.
module fp_div_seq #(
  parameter logic [31:0] QNAN   = 32'h7FC00000,
  localparam int         Q_BITS = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        div_zero,
  output logic        invalid
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic [24:0]        rem_q, rem_d, rem_kept;
  logic [23:0]        div_q, div_d;
  logic [26:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [2:0]         rmode_q, rmode_d;
  logic [31:0]        z_q, z_d;
  logic               ovrf_q, ovrf_d, udrf_q, udrf_d, dz_q, dz_d, inv_q, inv_d;

  logic               x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, sz_in, special, accept;
  logic [31:0]        spec_z;
  logic               spec_inv, spec_dz;
  logic               q_bit;
  logic               hi, g, st, inexact, inc;
  logic [22:0]        frac;
  logic [23:0]        frac_sum;
  logic signed [9:0]  e_pre, e_rnd;
  logic [31:0]        rnd_z;
  logic               rnd_ovf, rnd_udf;

  assign x_zero  = (fp_X[30:23] == 8'h00);
  assign y_zero  = (fp_Y[30:23] == 8'h00);
  assign x_inf   = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] == 23'h0);
  assign y_inf   = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] == 23'h0);
  assign x_nan   = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] != 23'h0);
  assign y_nan   = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] != 23'h0);
  assign sz_in   = fp_X[31] ^ fp_Y[31];
  assign special = x_zero | y_zero | (fp_X[30:23] == 8'hFF) | (fp_Y[30:23] == 8'hFF);
  assign accept  = (state_q == IDLE) && start;

  // Special-case result chosen by priority: invalid, Inf/y, x/Inf, x/0, 0/y
  always_comb begin
    spec_z   = {sz_in, 31'h0};
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_z   = QNAN;
      spec_inv = 1'b1;
    end else if (x_inf) begin
      spec_z = {sz_in, 8'hFF, 23'h0};
    end else if (y_inf) begin
      spec_z = {sz_in, 31'h0};
    end else if (y_zero) begin
      spec_z  = {sz_in, 8'hFF, 23'h0};
      spec_dz = 1'b1;
    end
  end

  // Normalize the quotient, apply the rounding mode and check the exponent range
  always_comb begin
    hi = quo_q[26];
    if (hi) begin
      frac  = quo_q[25:3];
      g     = quo_q[2];
      st    = (|quo_q[1:0]) | (|rem_q);
      e_pre = exp_q + 10'sd127;
    end else begin
      frac  = quo_q[24:2];
      g     = quo_q[1];
      st    = quo_q[0] | (|rem_q);
      e_pre = exp_q + 10'sd126;
    end
    inexact = g | st;
    case (rmode_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_q & inexact;
      3'b011:  inc = ~sign_q & inexact;
      3'b100:  inc = g;
      default: inc = g & (st | frac[0]);
    endcase
    frac_sum = {1'b0, frac} + {23'h0, inc};
    e_rnd    = e_pre + $signed({9'h0, frac_sum[23]});
    rnd_z    = {sign_q, e_rnd[7:0], frac_sum[22:0]};
    rnd_ovf  = 1'b0;
    rnd_udf  = 1'b0;
    if (e_rnd >= 10'sd255) begin
      rnd_z   = {sign_q, 8'hFF, 23'h0};
      rnd_ovf = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      rnd_z   = {sign_q, 31'h0};
      rnd_udf = 1'b1;
    end
  end

  // Next-state logic for the IDLE/DIV/ROUND/DONE sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = special ? DONE : DIV;
      DIV:     if (cnt_q == 5'(Q_BITS - 1)) state_d = ROUND;
      ROUND:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand capture, one restoring step per DIV cycle, result capture
  always_comb begin
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    rmode_d = rmode_q;
    z_d     = z_q;
    ovrf_d  = ovrf_q;
    udrf_d  = udrf_q;
    dz_d    = dz_q;
    inv_d   = inv_q;
    q_bit    = (rem_q >= {1'b0, div_q});
    rem_kept = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;
    if (accept) begin
      ovrf_d  = 1'b0;
      udrf_d  = 1'b0;
      dz_d    = 1'b0;
      inv_d   = 1'b0;
      sign_d  = sz_in;
      rmode_d = r_mode;
      if (special) begin
        z_d   = spec_z;
        dz_d  = spec_dz;
        inv_d = spec_inv;
      end else begin
        rem_d = {2'b01, fp_X[22:0]};
        div_d = {1'b1, fp_Y[22:0]};
        quo_d = 27'h0;
        cnt_d = 5'd0;
        exp_d = $signed({2'b00, fp_X[30:23]}) - $signed({2'b00, fp_Y[30:23]});
      end
    end else if (state_q == DIV) begin
      rem_d = {rem_kept[23:0], 1'b0};
      quo_d = {quo_q[25:0], q_bit};
      cnt_d = cnt_q + 5'd1;
    end else if (state_q == ROUND) begin
      z_d    = rnd_z;
      ovrf_d = rnd_ovf;
      udrf_d = rnd_udf;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      rmode_q <= '0;
      z_q     <= '0;
      ovrf_q  <= 1'b0;
      udrf_q  <= 1'b0;
      dz_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      rmode_q <= rmode_d;
      z_q     <= z_d;
      ovrf_q  <= ovrf_d;
      udrf_q  <= udrf_d;
      dz_q    <= dz_d;
      inv_q   <= inv_d;
    end
  end

  // Handshake outputs decoded from the state; results come straight from registers
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    fp_Z     = z_q;
    ovrf     = ovrf_q;
    udrf     = udrf_q;
    div_zero = dz_q;
    invalid  = inv_q;
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed testbench for fp_div_seq with a queue-based scoreboard of expected results.
module tb_fp_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] fp_X, fp_Y;
  logic [2:0]  r_mode;
  logic        busy, done, ovrf, udrf, div_zero, invalid;
  logic [31:0] fp_Z;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fp_X(fp_X), .fp_Y(fp_Y),
    .r_mode(r_mode), .busy(busy), .done(done), .fp_Z(fp_Z), .ovrf(ovrf),
    .udrf(udrf), .div_zero(div_zero), .invalid(invalid)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Drive one request; acceptance happens at the posedge inside this task
  task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                                input logic [31:0] ez, input logic [3:0] ef, input int elat,
                                input bit push);
    exp_t e;
    @(negedge clk);
    fp_X   = x;
    fp_Y   = y;
    r_mode = m;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (push) begin
      e.z   = ez;
      e.f   = ef;
      e.lat = elat;
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for done, then pop and compare the oldest expected result
  task automatic check_output(input string tag);
    int   lat;
    logic busy_ok;
    exp_t e;
    lat     = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    while (done !== 1'b1 && lat < 64) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check_val({tag, "_lat"}, 32'(lat), 32'(e.lat));
    check_val({tag, "_z"}, fp_Z, e.z);
    check_val({tag, "_flags"}, {28'h0, ovrf, udrf, div_zero, invalid}, {28'h0, e.f});
    check_val({tag, "_busy"}, {31'h0, busy_ok}, 32'h1);
    @(negedge clk);
    check_val({tag, "_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    logic saw_done;
    total  = 0;
    bad    = 0;
    start  = 1'b0;
    fp_X   = '0;
    fp_Y   = '0;
    r_mode = '0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_z", fp_Z, 32'h0);
    check_val("reset_ctl", {26'h0, busy, done, ovrf, udrf, div_zero, invalid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic division 9 / 3
    apply_stimulus(32'h41100000, 32'h40400000, 3'b001, 32'h40400000, 4'h0, 29, 1);
    check_output("div9by3");

    // 1/3 in several rounding modes
    apply_stimulus(32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 4'h0, 29, 1);
    check_output("third_rne");
    apply_stimulus(32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 4'h0, 29, 1);
    check_output("third_rtz");
    apply_stimulus(32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 4'h0, 29, 1);
    check_output("third_rmm");
    apply_stimulus(32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 4'h0, 29, 1);
    check_output("negthird_rdn");
    apply_stimulus(32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 4'h0, 29, 1);
    check_output("negthird_rup");

    // Special operands finish one cycle after acceptance; flags = {ovrf,udrf,div_zero,invalid}
    apply_stimulus(32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 4'b0010, 1, 1);
    check_output("div_by_zero");
    apply_stimulus(32'h00000000, 32'h80000000, 3'b000, 32'h7FC00000, 4'b0001, 1, 1);
    check_output("zero_by_zero");
    apply_stimulus(32'h7F800000, 32'hC0000000, 3'b000, 32'hFF800000, 4'b0000, 1, 1);
    check_output("inf_by_neg2");

    // Exponent range limits
    apply_stimulus(32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 4'b1000, 29, 1);
    check_output("overflow");
    apply_stimulus(32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 4'b0100, 29, 1);
    check_output("underflow");

    // A start pulsed during DIV must be ignored; waiting begins 5 edges after acceptance
    apply_stimulus(32'h41100000, 32'h40400000, 3'b000, 32'h40400000, 4'h0, 24, 1);
    repeat (5) @(negedge clk);
    fp_X  = 32'h3F800000;
    fp_Y  = 32'h00000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_output("ignored_start");
    saw_done = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check_val("no_second_done", {31'h0, saw_done}, 32'h0);
    check_val("held_z", fp_Z, 32'h40400000);

    // Reset in the middle of DIV aborts the operation
    apply_stimulus(32'h3F800000, 32'h40400000, 3'b000, 32'h0, 4'h0, 0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_z", fp_Z, 32'h0);
    check_val("abort_ctl", {26'h0, busy, done, ovrf, udrf, div_zero, invalid}, 32'h0);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check_val("abort_no_done", {31'h0, saw_done}, 32'h0);

    // Normal operation after reset release
    apply_stimulus(32'h41100000, 32'h40400000, 3'b000, 32'h40400000, 4'h0, 29, 1);
    check_output("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider, fp_Z = fp_X / fp_Y. It is the inverse-operation companion to the FP multiplier in the ALU.
- Uses radix-2 restoring division of the mantissas, one quotient bit per clock. Applies the same five rounding modes and the same flush-to-zero subnormal policy as the multiplier.
- Uses a start/busy/done handshake, so the ALU can issue a divide and wait on it.

Parameters:
- QNAN, 32'h7FC00000, canonical quiet NaN returned for invalid operations.
- Q_BITS, 27, quotient bits generated (1 integer + 26 fraction); fixed, not for override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- fp_X  in  32  dividend, sampled at the accepting edge
- fp_Y  in  32  divisor, sampled at the accepting edge
- r_mode  in  3  rounding mode, sampled at the accepting edge: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
- busy  out  1  high from the accepting edge until done
- done  out  1  one-cycle pulse; result outputs valid
- fp_Z  out  32  quotient, held until the next accepted start
- ovrf  out  1  overflow flag, held with fp_Z
- udrf  out  1  underflow (flushed) flag, held with fp_Z
- div_zero  out  1  finite nonzero divided by zero, held with fp_Z
- invalid  out  1  NaN result, held with fp_Z

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, fp_Z, ovrf, udrf, div_zero, invalid all 0; iteration counter 0. An operation in flight is aborted with no done.
- Operand class: exponent 0 means zero (subnormals flushed; the sign is kept). Exponent FF with fraction 0 is Inf; exponent FF with fraction nonzero is NaN.
- Sign: sZ = X[31]^Y[31] for every non-NaN result.
- States: IDLE, DIV, ROUND, DONE.
  - IDLE + start with a special case → DONE. The result is registered at the accepting edge, so done is high in the next cycle (latency 1).
  - IDLE + start with a normal case → DIV.
  - DIV runs exactly 27 cycles, then → ROUND.
  - ROUND runs 1 cycle, registers the result, then → DONE.
  - DONE runs 1 cycle with done=1, then → IDLE.
  - Normal latency: done is high 29 cycles after the accepting edge.
- start outside IDLE is ignored. start in the DONE cycle is also ignored; the next start is accepted in IDLE.
- Special cases, in priority order:
  1. Either operand NaN, 0/0, or Inf/Inf → QNAN, invalid=1.
  2. X Inf → {sZ, Inf}.
  3. Y Inf → {sZ, 0}.
  4. Y zero (X finite nonzero) → {sZ, Inf}, div_zero=1.
  5. X zero → {sZ, 0}.
- Divide datapath:
  - D = {1, Y frac} (24 bits). Remainder R starts at {1, X frac} in a 25-bit register.
  - Each DIV cycle: if R ≥ D then q bit = 1 and R = R − D, else q bit = 0. Then R <<= 1. Bits fill q[26] down to q[0].
  - Sticky s = (R != 0).
- Normalize:
  - If q[26]=1: frac=q[25:3], guard g=q[2], sticky st=|q[1:0] | s, E = eX − eY + 127.
  - Else: frac=q[24:2], g=q[1], st=q[0] | s, E = eX − eY + 126.
  - E is computed as 10-bit signed.
- Round (inexact = g|st):
  - RNE: increment if g & (st | frac[0]).
  - RTZ: no increment.
  - RDN: increment if sZ & inexact.
  - RUP: increment if !sZ & inexact.
  - RMM: increment if g.
  - An increment that carries out of the 23-bit fraction sets frac=0 and E=E+1.
- Range, checked after rounding:
  - E ≥ 255 → {sZ, Inf}, ovrf=1.
  - E ≤ 0 → {sZ, 0}, udrf=1.
  - Otherwise {sZ, E[7:0], frac}.
- Flags: all four flags are cleared at each accepted start, then set only as above.

Test Plan:
- 0x41100000 / 0x40400000, r_mode=001 → fp_Z=0x40400000, flags 0. done exactly 29 cycles after acceptance; busy=1 throughout.
- 0x3F800000 / 0x40400000: r_mode=000 → 0x3EAAAAAB; r_mode=001 → 0x3EAAAAAA; r_mode=100 → 0x3EAAAAAB.
- 0xBF800000 / 0x40400000: r_mode=010 → 0xBEAAAAAB; r_mode=011 → 0xBEAAAAAA.
- Specials, each with done 1 cycle after acceptance:
  - 0x3F800000 / 0x00000000 → 0x7F800000, div_zero=1.
  - 0x00000000 / 0x80000000 → 0x7FC00000, invalid=1.
  - 0x7F800000 / 0xC0000000 → 0xFF800000.
- 0x7F000000 / 0x3E800000, RNE → 0x7F800000, ovrf=1. 0x00800000 / 0x40000000 → 0x00000000, udrf=1.
- Second start pulsed mid-DIV → ignored; the first result is unchanged. rst_n low at DIV cycle 10 → all outputs 0 at once, no done. A new start after release completes normally.
